// File: rtl/battleship_turn_ctrl_if.sv
// rtl/battleship_turn_ctrl_if.sv - shot handshake and board lookup signals of the turn controller
interface battleship_turn_ctrl_if #(
  parameter int COORD_W = 7
);
  logic               fire_valid;
  logic [COORD_W-1:0] fire_coord;
  logic               fire_ready;
  logic               lookup_req;
  logic [COORD_W-1:0] lookup_coord;
  logic               lookup_board;
  logic               lookup_ack;
  logic               lookup_hit;

  modport master (
    input  fire_valid, fire_coord, lookup_ack, lookup_hit,
    output fire_ready, lookup_req, lookup_coord, lookup_board
  );

  modport slave (
    output fire_valid, fire_coord, lookup_ack, lookup_hit,
    input  fire_ready, lookup_req, lookup_coord, lookup_board
  );
endinterface

// File: rtl/battleship_turn_ctrl.sv
// rtl/battleship_turn_ctrl.sv - battleship game sequencer: turns, shot lookup, hit counting, timeout, winner
module battleship_turn_ctrl #(
  parameter int BOARD_CELLS  = 100,
  parameter int COORD_W      = 7,
  parameter int HITS_TO_WIN  = 17,
  parameter int HIT_W        = 5,
  parameter int TURN_TIMEOUT = 1000000000,
  parameter int TIMER_W      = 30
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  battleship_turn_ctrl_if.master bus,
  output logic [2:0]            state,
  output logic                  timeout,
  output logic [HIT_W-1:0]      p1_hits,
  output logic [HIT_W-1:0]      p2_hits
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_P1_AIM   = 3'd1,
    S_P1_CHECK = 3'd2,
    S_P2_AIM   = 3'd3,
    S_P2_CHECK = 3'd4,
    S_P1_WIN   = 3'd5,
    S_P2_WIN   = 3'd6
  } state_t;

  localparam logic [COORD_W:0]   CELLS_LIM  = (COORD_W+1)'(BOARD_CELLS);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TURN_TIMEOUT - 1);
  localparam logic [HIT_W-1:0]   WIN_HITS   = HIT_W'(HITS_TO_WIN);
  localparam logic [HIT_W-1:0]   HIT_MAX    = '1;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [HIT_W-1:0]     p1_q, p1_d, p2_q, p2_d;
  logic                 ready_q, ready_d;
  logic                 req_q, req_d;
  logic [COORD_W-1:0]   coord_q, coord_d;
  logic                 board_q, board_d;
  logic                 timeout_q, timeout_d;

  logic                 shot_ok;
  logic [HIT_W-1:0]     shooter_hits;
  logic [HIT_W-1:0]     hits_inc;

  assign shot_ok      = bus.fire_valid && ready_q && ({1'b0, bus.fire_coord} < CELLS_LIM);
  assign shooter_hits = (state_q == S_P1_CHECK) ? p1_q : p2_q;
  assign hits_inc     = (shooter_hits == HIT_MAX) ? shooter_hits : shooter_hits + 1'b1;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    req_d     = req_q;
    coord_d   = coord_q;
    board_d   = board_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE, S_P1_WIN, S_P2_WIN: begin
        if (start) begin
          state_d = S_P1_AIM;
          timer_d = '0;
          p1_d    = '0;
          p2_d    = '0;
        end
      end
      S_P1_AIM, S_P2_AIM: begin
        // A shot landing on the expiry cycle takes priority over the timeout
        if (shot_ok) begin
          coord_d = bus.fire_coord;
          board_d = (state_q == S_P1_AIM);
          req_d   = 1'b1;
          timer_d = '0;
          state_d = (state_q == S_P1_AIM) ? S_P1_CHECK : S_P2_CHECK;
        end else if (timer_q == TIMER_LAST) begin
          timeout_d = 1'b1;
          timer_d   = '0;
          state_d   = (state_q == S_P1_AIM) ? S_P2_AIM : S_P1_AIM;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_P1_CHECK, S_P2_CHECK: begin
        if (bus.lookup_ack) begin
          req_d = 1'b0;
          if (bus.lookup_hit) begin
            if (state_q == S_P1_CHECK) p1_d = hits_inc;
            else                       p2_d = hits_inc;
          end
          if (bus.lookup_hit && hits_inc == WIN_HITS)
            state_d = (state_q == S_P1_CHECK) ? S_P1_WIN : S_P2_WIN;
          else
            state_d = (state_q == S_P1_CHECK) ? S_P2_AIM : S_P1_AIM;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        timer_d = '0;
      end
    endcase
    ready_d = (state_d == S_P1_AIM) || (state_d == S_P2_AIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      p1_q      <= '0;
      p2_q      <= '0;
      ready_q   <= 1'b0;
      req_q     <= 1'b0;
      coord_q   <= '0;
      board_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      ready_q   <= ready_d;
      req_q     <= req_d;
      coord_q   <= coord_d;
      board_q   <= board_d;
      timeout_q <= timeout_d;
    end
  end

  assign state            = state_q;
  assign timeout          = timeout_q;
  assign p1_hits          = p1_q;
  assign p2_hits          = p2_q;
  assign bus.fire_ready   = ready_q;
  assign bus.lookup_req   = req_q;
  assign bus.lookup_coord = coord_q;
  assign bus.lookup_board = board_q;

endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// tb/tb_battleship_turn_ctrl.sv - bench for battleship_turn_ctrl: directed game scenarios plus random play against a game model
module tb_battleship_turn_ctrl;

  localparam int CELLS = 100;
  localparam int WIN   = 3;
  localparam int TO    = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] state;
  logic       timeout;
  logic [4:0] p1_hits, p2_hits;

  battleship_turn_ctrl_if #(.COORD_W(7)) bus ();

  battleship_turn_ctrl #(
    .BOARD_CELLS(CELLS), .COORD_W(7), .HITS_TO_WIN(WIN), .HIT_W(5),
    .TURN_TIMEOUT(TO), .TIMER_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .state(state), .timeout(timeout), .p1_hits(p1_hits), .p2_hits(p2_hits)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit auto_resp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: the player index selects the phase codes (aim 1+2p, check 2+2p, win 5+p)
  int m_state, m_timer, m_coord;
  int m_hits[2];
  bit m_ready, m_req, m_board, m_timeout;

  function automatic void m_reset();
    m_state = 0; m_timer = 0; m_coord = 0; m_hits[0] = 0; m_hits[1] = 0;
    m_ready = 0; m_req = 0; m_board = 0; m_timeout = 0;
  endfunction

  function automatic void m_step();
    int p;
    m_timeout = 0;
    if (m_state == 0 || m_state >= 5) begin
      if (start) begin
        m_state = 1; m_timer = 0; m_hits[0] = 0; m_hits[1] = 0;
      end
    end else if (m_state == 1 || m_state == 3) begin
      p = (m_state == 3) ? 1 : 0;
      if (bus.fire_valid && int'(bus.fire_coord) < CELLS) begin
        m_coord = int'(bus.fire_coord); m_board = (p == 0); m_req = 1;
        m_state = 2 + 2 * p; m_timer = 0;
      end else if (m_timer == TO - 1) begin
        m_timeout = 1; m_timer = 0; m_state = 1 + 2 * (1 - p);
      end else begin
        m_timer++;
      end
    end else begin
      p = (m_state == 4) ? 1 : 0;
      if (bus.lookup_ack) begin
        m_req = 0;
        if (bus.lookup_hit && m_hits[p] < 31) m_hits[p]++;
        m_state = (bus.lookup_hit && m_hits[p] == WIN) ? 5 + p : 1 + 2 * (1 - p);
      end
    end
    m_ready = (m_state == 1 || m_state == 3);
  endfunction

  initial begin : model
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else        m_step();
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("state", state, m_state);
        chk("fire_ready", bus.fire_ready, m_ready);
        chk("lookup_req", bus.lookup_req, m_req);
        chk("timeout", timeout, m_timeout);
        chk("p1_hits", p1_hits, m_hits[0]);
        chk("p2_hits", p2_hits, m_hits[1]);
        if (m_req) begin
          chk("lookup_coord", bus.lookup_coord, m_coord);
          chk("lookup_board", bus.lookup_board, m_board);
        end
      end
    end
  end

  initial begin : responder
    int dly = 0;
    forever begin
      @(negedge clk);
      if (auto_resp) begin
        if (bus.lookup_ack) begin
          bus.lookup_ack = 1'b0;
        end else if (bus.lookup_req) begin
          if (dly == 0) begin
            bus.lookup_ack = 1'b1;
            bus.lookup_hit = 1'($urandom_range(1));
            dly = $urandom_range(3);
          end else begin
            dly--;
          end
        end else if ($urandom_range(49) == 0) begin
          bus.lookup_ack = 1'b1;
          bus.lookup_hit = 1'b1;
        end
      end
    end
  end

  task automatic wait_state(input int code, input int budget);
    int k = 0;
    while (state !== 3'(code) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_state", state, code);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic shoot(input int c, input bit h);
    bus.fire_valid = 1'b1;
    bus.fire_coord = 7'(c);
    @(negedge clk);
    bus.fire_valid = 1'b0;
    bus.lookup_ack = 1'b1;
    bus.lookup_hit = h;
    @(negedge clk);
    bus.lookup_ack = 1'b0;
  endtask

  initial begin : stim
    int n;
    bus.fire_valid = 1'b0; bus.fire_coord = '0;
    bus.lookup_ack = 1'b0; bus.lookup_hit = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_ready", bus.fire_ready, 0);
    chk("rst_req", bus.lookup_req, 0);
    chk("rst_hits", {p1_hits, p2_hits}, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_hold", state, 0);

    pulse_start();
    chk("start_state", state, 1);
    chk("start_ready", bus.fire_ready, 1);

    // P1 fires 42, ack arrives in the fourth request cycle
    bus.fire_valid = 1'b1; bus.fire_coord = 7'd42;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.fire_valid = 1'b0;
      bus.lookup_ack = 1'b0;
      if (bus.lookup_req) n++;
      if (i == 0) begin
        chk("coord42", bus.lookup_coord, 42);
        chk("board42", bus.lookup_board, 1);
      end
      if (i == 3) begin
        bus.lookup_ack = 1'b1; bus.lookup_hit = 1'b1;
      end
    end
    chk("req_cycles", n, 4);
    chk("hit42_p1", p1_hits, 1);
    chk("hit42_state", state, 3);

    shoot(5, 1'b0);
    chk("p2_miss_state", state, 1);

    bus.fire_valid = 1'b1; bus.fire_coord = 7'd100;
    repeat (2) begin
      @(negedge clk);
      chk("coord100_state", state, 1);
      chk("coord100_req", bus.lookup_req, 0);
    end
    bus.fire_coord = 7'd99;
    @(negedge clk);
    bus.fire_valid = 1'b0;
    chk("coord99_state", state, 2);
    chk("coord99_coord", bus.lookup_coord, 99);
    bus.lookup_ack = 1'b1; bus.lookup_hit = 1'b0;
    @(negedge clk);
    bus.lookup_ack = 1'b0;

    // P2 lets its turn expire, then P1 does too
    wait_state(1, 40);
    n = 0;
    do begin
      n++;
      @(negedge clk);
    end while (state == 3'd1 && n < 40);
    chk("aim_cycles", n, 8);
    chk("to_pulse", timeout, 1);
    chk("to_state", state, 3);
    chk("to_p1_hits", p1_hits, 1);

    repeat (7) @(negedge clk);
    chk("pre_expiry_state", state, 3);
    bus.fire_valid = 1'b1; bus.fire_coord = 7'd7;
    @(negedge clk);
    bus.fire_valid = 1'b0;
    chk("expiry_shot_state", state, 4);
    chk("expiry_shot_to", timeout, 0);
    bus.lookup_ack = 1'b1; bus.lookup_hit = 1'b0;
    @(negedge clk);
    bus.lookup_ack = 1'b0;

    bus.fire_valid = 1'b1; bus.fire_coord = 7'd10;
    @(negedge clk);
    bus.fire_valid = 1'b0;
    chk("pre_rst_state", state, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_req", bus.lookup_req, 0);
    @(negedge clk);
    bus.lookup_ack = 1'b1; bus.lookup_hit = 1'b1;
    @(negedge clk);
    bus.lookup_ack = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    bus.lookup_ack = 1'b1;
    @(negedge clk);
    bus.lookup_ack = 1'b0;
    chk("late_ack_state", state, 0);
    chk("late_ack_hits", p1_hits, 0);

    pulse_start();
    shoot(1, 1'b1); shoot(2, 1'b0);
    shoot(3, 1'b1); shoot(4, 1'b0);
    shoot(5, 1'b1);
    chk("p1_win_state", state, 5);
    chk("p1_win_ready", bus.fire_ready, 0);
    chk("p1_win_hits", p1_hits, 3);
    bus.lookup_ack = 1'b1; bus.lookup_hit = 1'b1;
    @(negedge clk);
    bus.lookup_ack = 1'b0;
    @(negedge clk);
    chk("p1_frozen", p1_hits, 3);
    pulse_start();
    chk("restart_state", state, 1);
    chk("restart_hits", {p1_hits, p2_hits}, 0);

    shoot(11, 1'b0); shoot(12, 1'b1);
    shoot(13, 1'b0); shoot(14, 1'b1);
    shoot(15, 1'b0);
    bus.fire_valid = 1'b1; bus.fire_coord = 7'd16;
    @(negedge clk);
    bus.fire_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_check", state, 4);
    bus.lookup_ack = 1'b1; bus.lookup_hit = 1'b1;
    @(negedge clk);
    bus.lookup_ack = 1'b0;
    chk("p2_win_state", state, 6);
    chk("p2_win_hits", p2_hits, 3);

    // Random play: out-of-range coords, stray acks, restarts and one mid-game reset
    auto_resp = 1'b1;
    pulse_start();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start          = ($urandom_range(39) == 0);
      bus.fire_valid = ($urandom_range(3) == 0);
      bus.fire_coord = 7'($urandom_range(127));
      if (i == 2000) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    auto_resp = 1'b0;
    start = 1'b0; bus.fire_valid = 1'b0; bus.lookup_ack = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/battleship_turn_ctrl.md
Name: battleship_turn_ctrl

Overview:
- Game sequencer for keyboard battleship; owns the 3-bit game `state` bus that drives the win-detection and display logic.
- Alternates turns between P1 and P2 and accepts shot coordinates from the keyboard decoder via a valid/ready handshake.
- Queries the opponent board via a req/ack lookup, counts hits per player, enforces a per-turn timeout and declares the winner.

Parameters:
- BOARD_CELLS, 100, legal cell indices are 0..BOARD_CELLS-1
- COORD_W, 7, cell index width
- HITS_TO_WIN, 17, hits needed to sink the whole fleet (5+4+3+3+2)
- HIT_W, 5, hit counter width
- TURN_TIMEOUT, 1000000000, clk cycles allowed per aim phase
- TIMER_W, 30, turn timer width

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; new game
- fire_valid  in  1  shot coordinate offered
- fire_coord  in  COORD_W  shot cell index
- fire_ready  out  1  controller accepts a shot this cycle
- lookup_req  out  1  board query pending
- lookup_coord  out  COORD_W  cell being queried
- lookup_board  out  1  board queried: 0 = P1's board, 1 = P2's board
- lookup_ack  in  1  one-cycle query completion
- lookup_hit  in  1  query result, valid with lookup_ack
- state  out  3  0 IDLE, 1 P1_AIM, 2 P1_CHECK, 3 P2_AIM, 4 P2_CHECK, 5 P1_WIN, 6 P2_WIN
- timeout  out  1  one-cycle pulse when a turn expires
- p1_hits  out  HIT_W  hits scored by P1
- p2_hits  out  HIT_W  hits scored by P2

Behaviour:
- Reset (async, rst_n=0): the following are 0 and held while rst_n=0 — state=IDLE, fire_ready, lookup_req, lookup_coord, lookup_board, timeout, hit counters, turn timer. Reset mid-turn or mid-lookup abandons the operation; a late lookup_ack is ignored.
- All outputs are registered. fire_ready=1 exactly while state is P1_AIM or P3_AIM… specifically P1_AIM or P2_AIM.
- IDLE:
  - start -> P1_AIM.
  - Clear both hit counters and the turn timer.
- P1_AIM / P2_AIM:
  - Timer increments every cycle.
  - Accepted shot (fire_valid & fire_ready & fire_coord < BOARD_CELLS):
    - latch lookup_coord=fire_coord;
    - lookup_board = opponent (1 in P1_AIM, 0 in P2_AIM);
    - lookup_req=1 next cycle;
    - go to the matching CHECK state;
    - timer cleared.
  - fire_coord >= BOARD_CELLS: shot dropped, no state change, timer keeps running.
  - Timer reaching TURN_TIMEOUT-1 with no accepted shot:
    - timeout pulses 1 cycle;
    - timer cleared;
    - turn passes (P1_AIM -> P2_AIM, P2_AIM -> P1_AIM).
  - Accepted shot and timeout expiry in the same cycle: the shot wins and no timeout pulse occurs.
- P1_CHECK / P2_CHECK:
  - lookup_req stays high until the cycle after lookup_ack is sampled, then drops.
  - On lookup_ack with lookup_hit=1, the shooter's counter increments. If the new value equals HITS_TO_WIN, go to P1_WIN / P2_WIN; otherwise go to the opponent's AIM.
  - On lookup_ack with lookup_hit=0, go to the opponent's AIM.
  - No timeout in CHECK; the state waits indefinitely for ack.
  - lookup_ack outside CHECK is ignored.
- P1_WIN / P2_WIN:
  - Terminal; counters frozen; fire_ready=0.
  - start -> P1_AIM with counters and timer cleared (same as from IDLE).
- start is ignored in the AIM and CHECK states.
- Counters saturate at 2^HIT_W-1; they cannot in practice exceed HITS_TO_WIN.
- State value 7 (illegal) -> IDLE on the next clk.
- Latency: accepted shot -> lookup_req high is 1 cycle; lookup_ack -> new state value is 1 cycle.

Test Plan:
- Reset then start -> state 0 then 1, fire_ready=1, p1_hits=p2_hits=0. Assert rst_n=0 while in P1_CHECK -> state=0 and lookup_req=0 immediately, without waiting for clk.
- P1 fires coord 42, board returns ack with hit=1 after 3 cycles:
  - lookup_req=1 with lookup_coord=42 and lookup_board=1 for exactly 4 cycles;
  - p1_hits=1;
  - state=3 the cycle after ack.
- Shot with coord 100 in P1_AIM -> no lookup_req, state stays 1. Then coord 99 -> accepted.
- TURN_TIMEOUT=8, no fire -> timeout pulse on the 8th AIM cycle, state 1->3, p1_hits unchanged. Fire on the expiry cycle -> state 2 and no timeout pulse.
- HITS_TO_WIN=3; P1 hits three times while P2 misses -> state=5 after the 3rd P1 ack, fire_ready=0. A further ack leaves p1_hits=3. start -> state=1 with counters 0.
- Mirror of the previous scenario for P2 -> state=6 and p2_hits=3. Pulse start during P2_CHECK -> ignored.
